can_node_ctrl: RTL and testbench
================================

Name: can_node_ctrl

Overview:
- Parametrised successor of the CAN top-level sequencer.
- Arbitrates one CAN link between an external receive engine and an external transmit engine.
- Adds a DEPTH-entry transmit message queue, bounded retransmission with back-off, a start-handshake timeout, and status pulses.
- Sits between host logic and the can_tx / can_rx engines, and drives the shared tx pin mux.

Parameters:
ID_W, 29, message identifier width (extended frame)
DEPTH, 4, transmit queue entries; power of two, 2..16
MAX_RETRY, 3, transmission attempts per message before it is dropped
BACKOFF_CYC, 64, clk_i cycles to wait in BACKOFF after a failed attempt
START_TMO, 255, clk_i cycles allowed for an engine to raise busy after start

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-low reset
tx_wr_i  in  1  host enqueue strobe, one message per cycle high
tx_id_i  in  ID_W  identifier of the message being enqueued
tx_dlc_i  in  4  data length code
tx_data_i  in  64  payload
tx_full_o  out  1  queue full
tx_level_o  out  clog2(DEPTH)+1  queue occupancy
tx_overflow_o  out  1  1-cycle pulse: write attempted while full
tx_done_o  out  1  1-cycle pulse: head message acknowledged
tx_fail_o  out  1  1-cycle pulse: head message dropped after MAX_RETRY attempts
bus_idle_i  in  1  bus-idle indication from the rx engine (11 recessive bits)
eng_tx_start_o  out  1  start request to the tx engine
eng_tx_busy_i  in  1  tx engine busy
eng_tx_lost_i  in  1  arbitration lost (level, valid while busy)
eng_tx_ack_i  in  1  frame acknowledged (level, valid at busy fall)
eng_tx_id_o / eng_tx_dlc_o / eng_tx_data_o  out  ID_W/4/64  queue head fields
eng_rx_start_o  out  1  start request to the rx engine
eng_rx_busy_i  in  1  rx engine busy
eng_tx_pin_i  in  1  tx engine pin drive
eng_rx_pin_i  in  1  rx engine pin drive (ack slot)
tx_o  out  1  CAN tx pin
state_o  out  3  current FSM state (debug)

Behaviour:
- Reset (asynchronous, rst_i=0):
  - FSM goes to IDLE; queue is emptied (pointers 0, level 0); retry counter is 0.
  - All start outputs and pulse outputs are 0.
  - tx_o is 1; tx_full_o is 0.
  - Reset asserted mid-frame aborts immediately. No pulse is issued.
- Queue:
  - Write when tx_wr_i=1 and not full. A write while full is dropped and raises tx_overflow_o.
  - Pop occurs on success or on final failure. A write and a pop in the same cycle are both performed; level is unchanged.
  - Pointers wrap modulo DEPTH.
  - eng_tx_* outputs show the head entry combinationally from registered storage.
- tx_o mux (registered state, combinational mux):
  - START_TX/TX: tx_o = eng_tx_pin_i.
  - START_RX/RX: tx_o = eng_rx_pin_i.
  - Otherwise: tx_o = 1.
- FSM, encodings 0..6: IDLE, START_RX, RX, START_TX, TX, BACKOFF, TMO_WAIT.
  - IDLE: if queue non-empty and bus_idle_i=1, go to START_TX; else go to START_RX.
  - START_RX:
    - eng_rx_start_o=1.
    - eng_rx_busy_i=1 → RX.
    - Else if queue non-empty and bus_idle_i=1 → IDLE (rx start dropped).
    - Else if timer reaches START_TMO → IDLE.
  - RX: eng_rx_start_o held at 1. On eng_rx_busy_i=0, eng_rx_start_o goes to 0 and the FSM goes to IDLE.
  - START_TX:
    - eng_tx_start_o=1.
    - eng_tx_busy_i=1 → TX, and eng_tx_start_o goes to 0 in the same edge.
    - If the timer reaches START_TMO, the attempt counts as a failure (see failure rule).
  - TX:
    - A lost flag is latched if eng_tx_lost_i=1 during busy.
    - On eng_tx_busy_i=0:
      - If ack=1 and lost=0: pop, tx_done_o pulse, retry=0, go to IDLE.
      - Otherwise apply the failure rule.
  - Failure rule:
    - retry+1 == MAX_RETRY: pop, tx_fail_o pulse, retry=0, go to IDLE.
    - Otherwise: retry+1, go to BACKOFF.
  - BACKOFF: count BACKOFF_CYC cycles, then go to IDLE. The queue accepts writes during BACKOFF.
  - TMO_WAIT: reserved. Any entry goes to IDLE on the next cycle.
- Timer:
  - One shared 8-bit-minimum counter, cleared on every state change.
  - START_TMO=0 disables the timeout.
- Latency:
  - Enqueue to eng_tx_start_o with an idle bus and the FSM in IDLE: 2 cycles.
  - Done/fail pulses are asserted the cycle after the busy falling edge is sampled.

Test Plan:
- Reset, enqueue id=0x1ABCDEF, dlc=8, with bus_idle=1 and an engine model that acks → eng_tx_start_o high 2 cycles after write, one tx_done_o pulse, tx_level_o returns to 0.
- Enqueue 5 messages with DEPTH=4 → tx_full_o=1 after the 4th, tx_overflow_o pulse on the 5th, level stays 4; drain in order 1..4 with done pulses.
- Engine reports lost on every attempt, MAX_RETRY=3 → three START_TX entries separated by ≥64-cycle BACKOFF, then tx_fail_o pulse and pop; the next message starts.
- Engine never raises busy → after 255 cycles in START_TX a failure is counted; after 3 attempts a tx_fail_o pulse.
- Rx frame in progress (rx_busy=1) while a message is queued → no tx start until rx_busy falls; then IDLE→START_TX. tx_o follows eng_rx_pin_i in RX and eng_tx_pin_i in TX.
- rst_i low mid-TX with 2 queued → all outputs reset, level 0, no done/fail pulse, tx_o=1.

Source files
------------

// File: rtl/can_node_ctrl.sv
// can_node_ctrl: CAN link sequencer. It arbitrates a single CAN link between
// external rx and tx engines, holds a DEPTH-entry transmit queue, retries
// failed transmissions a bounded number of times with back-off, bounds the
// engine start handshake with a timeout, and drives the shared tx pin mux.
module can_node_ctrl #(
  parameter int ID_W        = 29,
  parameter int DEPTH       = 4,
  parameter int MAX_RETRY   = 3,
  parameter int BACKOFF_CYC = 64,
  parameter int START_TMO   = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // host enqueue side
  input  logic                     tx_wr_i,
  input  logic [ID_W-1:0]          tx_id_i,
  input  logic [3:0]               tx_dlc_i,
  input  logic [63:0]              tx_data_i,
  output logic                     tx_full_o,
  output logic [$clog2(DEPTH):0]   tx_level_o,
  output logic                     tx_overflow_o,
  output logic                     tx_done_o,
  output logic                     tx_fail_o,
  // bus and engine side
  input  logic                     bus_idle_i,
  output logic                     eng_tx_start_o,
  input  logic                     eng_tx_busy_i,
  input  logic                     eng_tx_lost_i,
  input  logic                     eng_tx_ack_i,
  output logic [ID_W-1:0]          eng_tx_id_o,
  output logic [3:0]               eng_tx_dlc_o,
  output logic [63:0]              eng_tx_data_o,
  output logic                     eng_rx_start_o,
  input  logic                     eng_rx_busy_i,
  input  logic                     eng_tx_pin_i,
  input  logic                     eng_rx_pin_i,
  output logic                     tx_o,
  output logic [2:0]               state_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int TMR_MAX = (BACKOFF_CYC > START_TMO) ? BACKOFF_CYC : START_TMO;
  localparam int TMR_W   = ($clog2(TMR_MAX + 1) > 8) ? $clog2(TMR_MAX + 1) : 8;
  localparam int RTY_W   = ($clog2(MAX_RETRY + 1) > 1) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START_RX = 3'd1,
    ST_RX       = 3'd2,
    ST_START_TX = 3'd3,
    ST_TX       = 3'd4,
    ST_BACKOFF  = 3'd5,
    ST_TMO_WAIT = 3'd6
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [3:0]      dlc;
    logic [63:0]     data;
  } msg_t;

  // ---------------------------------------------------------------------
  // Transmit queue state
  // ---------------------------------------------------------------------
  msg_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             overflow_q;

  logic             q_full, q_empty, wr_en, pop;
  msg_t             head;

  // ---------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------
  state_e           state_q;
  logic [TMR_W-1:0] timer_q;
  logic [RTY_W-1:0] retry_q;
  logic             lost_q;
  logic             tx_start_q, rx_start_q;
  logic             tx_done_q, tx_fail_q;

  logic             tmo_hit, tx_ok, attempt_fail, last_try, final_fail;

  assign q_full  = (level_q == LVL_W'(DEPTH));
  assign q_empty = (level_q == '0);
  assign wr_en   = tx_wr_i && !q_full;
  assign head    = mem_q[rd_ptr_q];

  // A zero START_TMO means the handshake may take forever.
  assign tmo_hit  = (START_TMO != 0) && (timer_q == TMR_W'(START_TMO));
  assign last_try = ((32'(retry_q) + 32'd1) == 32'(MAX_RETRY));

  // Classify the current cycle's attempt outcome.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    tx_ok        = 1'b0;
    attempt_fail = 1'b0;
    if (state_q == ST_TX && !eng_tx_busy_i) begin
      if (eng_tx_ack_i && !lost_q) tx_ok        = 1'b1;
      else                         attempt_fail = 1'b1;
    end else if (state_q == ST_START_TX && !eng_tx_busy_i && tmo_hit) begin
      attempt_fail = 1'b1;
    end
  end

  assign final_fail = attempt_fail && last_try;
  assign pop        = (tx_ok || final_fail) && !q_empty;

  // Queue payload storage.
  // NOTE: the message array carries no reset; validity is tracked by the
  // reset pointers and level, so clearing the data would only cost logic.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= '{id: tx_id_i, dlc: tx_dlc_i, data: tx_data_i};
  end

  // Queue pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: registers are updated with non-blocking assignments so every
      // flop samples the pre-edge values regardless of statement order.
      overflow_q <= tx_wr_i && q_full;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Link sequencer with registered start and status outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      retry_q    <= '0;
      lost_q     <= 1'b0;
      tx_start_q <= 1'b0;
      rx_start_q <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_fail_q  <= 1'b0;
    end else begin
      timer_q   <= timer_q + 1'b1;
      tx_done_q <= 1'b0;
      tx_fail_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          if (!q_empty && bus_idle_i) begin
            state_q    <= ST_START_TX;
            tx_start_q <= 1'b1;
          end else begin
            state_q    <= ST_START_RX;
            rx_start_q <= 1'b1;
          end
        end
        ST_START_RX: begin
          if (eng_rx_busy_i) begin
            state_q <= ST_RX;
            timer_q <= '0;
          end else if ((!q_empty && bus_idle_i) || tmo_hit) begin
            // Pending tx traffic on an idle bus pre-empts listening.
            state_q    <= ST_IDLE;
            rx_start_q <= 1'b0;
            timer_q    <= '0;
          end
        end
        ST_RX: begin
          if (!eng_rx_busy_i) begin
            state_q    <= ST_IDLE;
            rx_start_q <= 1'b0;
            timer_q    <= '0;
          end
        end
        ST_START_TX: begin
          if (eng_tx_busy_i) begin
            state_q    <= ST_TX;
            tx_start_q <= 1'b0;
            lost_q     <= eng_tx_lost_i;
            timer_q    <= '0;
          end else if (tmo_hit) begin
            tx_start_q <= 1'b0;
          end
        end
        ST_TX: begin
          if (eng_tx_busy_i) begin
            if (eng_tx_lost_i) lost_q <= 1'b1;
          end else if (tx_ok) begin
            state_q   <= ST_IDLE;
            tx_done_q <= 1'b1;
            retry_q   <= '0;
            timer_q   <= '0;
          end
        end
        ST_BACKOFF: begin
          if (timer_q == TMR_W'(BACKOFF_CYC - 1)) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
          end
        end
        default: begin
          // TMO_WAIT is reserved and always falls straight back to IDLE.
          state_q <= ST_IDLE;
          timer_q <= '0;
        end
      endcase

      // A failed attempt either drops the head message or schedules a retry.
      if (attempt_fail) begin
        timer_q <= '0;
        if (last_try) begin
          state_q   <= ST_IDLE;
          tx_fail_q <= 1'b1;
          retry_q   <= '0;
        end else begin
          state_q <= ST_BACKOFF;
          retry_q <= retry_q + 1'b1;
        end
      end
    end
  end

  // Pin ownership follows the registered state; only the mux is combinational.
  always_comb begin
    tx_o = 1'b1;
    case (state_q)
      ST_START_TX, ST_TX: tx_o = eng_tx_pin_i;
      ST_START_RX, ST_RX: tx_o = eng_rx_pin_i;
      default:            tx_o = 1'b1;
    endcase
  end

  assign tx_full_o      = q_full;
  assign tx_level_o     = level_q;
  assign tx_overflow_o  = overflow_q;
  assign tx_done_o      = tx_done_q;
  assign tx_fail_o      = tx_fail_q;
  assign eng_tx_start_o = tx_start_q;
  assign eng_rx_start_o = rx_start_q;
  assign eng_tx_id_o    = head.id;
  assign eng_tx_dlc_o   = head.dlc;
  assign eng_tx_data_o  = head.data;
  assign state_o        = state_q;

endmodule

// File: tb/tb_can_node_ctrl.sv
// tb_can_node_ctrl: directed stimulus with a pulse scoreboard for
// can_node_ctrl. Expected done/fail outcomes are queued as stimulus is
// issued; a monitor pops and compares them when the DUT pulses.
module tb_can_node_ctrl;

  localparam int ID_W        = 29;
  localparam int DEPTH       = 4;
  localparam int MAX_RETRY   = 3;
  localparam int BACKOFF_CYC = 64;
  localparam int START_TMO   = 255;

  localparam logic [2:0] S_IDLE = 3'd0, S_START_RX = 3'd1, S_RX = 3'd2,
                         S_START_TX = 3'd3, S_TX = 3'd4, S_BACKOFF = 3'd5;

  typedef enum int {M_ACK, M_LOST, M_NORESP} eng_mode_e;

  typedef struct {
    logic            fail;
    logic [ID_W-1:0] id;
    int              attempts;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic tx_wr_i;
  logic [ID_W-1:0] tx_id_i;
  logic [3:0] tx_dlc_i;
  logic [63:0] tx_data_i;
  logic tx_full_o;
  logic [$clog2(DEPTH):0] tx_level_o;
  logic tx_overflow_o, tx_done_o, tx_fail_o;
  logic bus_idle_i;
  logic eng_tx_start_o, eng_tx_busy_i, eng_tx_lost_i, eng_tx_ack_i;
  logic [ID_W-1:0] eng_tx_id_o;
  logic [3:0] eng_tx_dlc_o;
  logic [63:0] eng_tx_data_o;
  logic eng_rx_start_o, eng_rx_busy_i, eng_tx_pin_i, eng_rx_pin_i;
  logic tx_o;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sb[$];
  eng_mode_e mode = M_ACK;

  can_node_ctrl #(
    .ID_W(ID_W), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY),
    .BACKOFF_CYC(BACKOFF_CYC), .START_TMO(START_TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tx_wr_i(tx_wr_i), .tx_id_i(tx_id_i), .tx_dlc_i(tx_dlc_i), .tx_data_i(tx_data_i),
    .tx_full_o(tx_full_o), .tx_level_o(tx_level_o), .tx_overflow_o(tx_overflow_o),
    .tx_done_o(tx_done_o), .tx_fail_o(tx_fail_o),
    .bus_idle_i(bus_idle_i),
    .eng_tx_start_o(eng_tx_start_o), .eng_tx_busy_i(eng_tx_busy_i),
    .eng_tx_lost_i(eng_tx_lost_i), .eng_tx_ack_i(eng_tx_ack_i),
    .eng_tx_id_o(eng_tx_id_o), .eng_tx_dlc_o(eng_tx_dlc_o), .eng_tx_data_o(eng_tx_data_o),
    .eng_rx_start_o(eng_rx_start_o), .eng_rx_busy_i(eng_rx_busy_i),
    .eng_tx_pin_i(eng_tx_pin_i), .eng_rx_pin_i(eng_rx_pin_i),
    .tx_o(tx_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_exp(input logic fail, input logic [ID_W-1:0] id, input int attempts);
    exp_t e;
    e.fail = fail; e.id = id; e.attempts = attempts;
    sb.push_back(e);
  endtask

  task automatic enq(input logic [ID_W-1:0] id, input logic [3:0] dlc, input logic [63:0] d);
    @(negedge clk_i);
    tx_wr_i = 1'b1; tx_id_i = id; tx_dlc_i = dlc; tx_data_i = d;
    @(negedge clk_i);
    tx_wr_i = 1'b0;
  endtask

  task automatic wait_sb(input int target, input int budget, input string name);
    int n = 0;
    while (sb.size() > target && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check(name, 64'(sb.size() <= target), 64'd1);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int n = 0;
    while (state_o !== st && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check(name, 64'(state_o), 64'(st));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"},    64'(tx_level_o), 64'd0);
    check({tag, "_full"},     64'(tx_full_o), 64'd0);
    check({tag, "_tx_o"},     64'(tx_o), 64'd1);
    check({tag, "_txstart"},  64'(eng_tx_start_o), 64'd0);
    check({tag, "_rxstart"},  64'(eng_rx_start_o), 64'd0);
    check({tag, "_pulses"},   64'({tx_done_o, tx_fail_o, tx_overflow_o}), 64'd0);
    check({tag, "_state"},    64'(state_o), 64'(S_IDLE));
  endtask

  // Tx engine model: answers a start request with a busy window.
  initial begin
    eng_tx_busy_i = 1'b0; eng_tx_lost_i = 1'b0; eng_tx_ack_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (rst_i && eng_tx_start_o && mode != M_NORESP) begin
        repeat (2) begin @(posedge clk_i); #1; end
        eng_tx_busy_i = 1'b1;
        repeat (3) begin @(posedge clk_i); #1; end
        if (mode == M_LOST) eng_tx_lost_i = 1'b1;
        repeat (2) begin @(posedge clk_i); #1; end
        eng_tx_lost_i = 1'b0;
        repeat (3) begin @(posedge clk_i); #1; end
        eng_tx_ack_i  = 1'b1;
        eng_tx_busy_i = 1'b0;
        @(posedge clk_i); #1;
        eng_tx_ack_i = 1'b0;
      end
    end
  end

  // Monitor: scores done/fail pulses and measures state dwell times.
  initial begin
    int attempts = 0, bo_cnt = 0, st_cnt = 0;
    logic start_prev = 1'b0;
    logic [ID_W-1:0] cur_id = '0;
    exp_t e;
    forever begin
      @(posedge clk_i); #1;
      if (!rst_i) begin
        attempts = 0; bo_cnt = 0; st_cnt = 0; start_prev = 1'b0;
      end else begin
        if (eng_tx_start_o && !start_prev) begin
          attempts++;
          cur_id = eng_tx_id_o;
        end
        start_prev = eng_tx_start_o;
        if (state_o == S_BACKOFF) bo_cnt++;
        else if (bo_cnt > 0) begin
          check("backoff_len", 64'(bo_cnt), 64'(BACKOFF_CYC));
          bo_cnt = 0;
        end
        if (state_o == S_START_TX) st_cnt++;
        else if (st_cnt > 0) begin
          if (state_o != S_TX)
            check("start_tmo_len", 64'(st_cnt == START_TMO || st_cnt == START_TMO + 1), 64'd1);
          st_cnt = 0;
        end
        if (tx_done_o || tx_fail_o) begin
          if (sb.size() == 0) check("unexpected_pulse", {62'd0, tx_done_o, tx_fail_o}, 64'd0);
          else begin
            e = sb.pop_front();
            check("pulse_kind", {62'd0, tx_done_o, tx_fail_o}, e.fail ? 64'd1 : 64'd2);
            check("pulse_id", 64'(cur_id), 64'(e.id));
            check("pulse_attempts", 64'(attempts), 64'(e.attempts));
          end
          attempts = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts;
    rst_i = 1'b0; tx_wr_i = 1'b0; tx_id_i = '0; tx_dlc_i = '0; tx_data_i = '0;
    bus_idle_i = 1'b1; eng_rx_busy_i = 1'b0; eng_tx_pin_i = 1'b1; eng_rx_pin_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("rst");
    rst_i = 1'b1;

    // Single message, acked on the first attempt.
    push_exp(1'b0, 29'h1ABCDEF, 1);
    enq(29'h1ABCDEF, 4'd8, 64'h0123_4567_89AB_CDEF);
    begin
      int n = 0;
      while (!eng_tx_start_o && n < 8) begin @(negedge clk_i); n++; end
    end
    check("t1_start", 64'(eng_tx_start_o), 64'd1);
    check("t1_id", 64'(eng_tx_id_o), 64'h1ABCDEF);
    check("t1_dlc", 64'(eng_tx_dlc_o), 64'd8);
    check("t1_data", eng_tx_data_o, 64'h0123_4567_89AB_CDEF);
    wait_sb(0, 200, "t1_done");
    check("t1_level", 64'(tx_level_o), 64'd0);

    // Fill to overflow with the bus busy, then drain in order.
    bus_idle_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk_i);
      check("t2_level_fill", 64'(tx_level_o), 64'(i - 1));
      if (i == 5) begin
        check("t2_full", 64'(tx_full_o), 64'd1);
        check("t2_no_ovf_yet", 64'(tx_overflow_o), 64'd0);
      end
      tx_wr_i = 1'b1; tx_id_i = ID_W'(i); tx_dlc_i = 4'(i); tx_data_i = 64'(i * 17);
    end
    @(negedge clk_i);
    tx_wr_i = 1'b0;
    check("t2_ovf_pulse", 64'(tx_overflow_o), 64'd1);
    check("t2_level_4", 64'(tx_level_o), 64'd4);
    @(negedge clk_i);
    check("t2_ovf_clear", 64'(tx_overflow_o), 64'd0);
    for (int i = 1; i <= 4; i++) push_exp(1'b0, ID_W'(i), 1);
    bus_idle_i = 1'b1;
    wait_sb(0, 500, "t2_drain");
    check("t2_empty", 64'({tx_full_o, tx_level_o}), 64'd0);

    // Arbitration lost every time: dropped after MAX_RETRY, next one sent.
    mode = M_LOST;
    push_exp(1'b1, 29'h100, MAX_RETRY);
    push_exp(1'b0, 29'h101, 1);
    enq(29'h100, 4'd1, 64'hAA);
    enq(29'h101, 4'd2, 64'hBB);
    wait_sb(1, 1000, "t3_fail");
    mode = M_ACK;
    wait_sb(0, 300, "t3_next_done");

    // Engine never raises busy: handshake timeouts count as failures.
    mode = M_NORESP;
    push_exp(1'b1, 29'h200, MAX_RETRY);
    enq(29'h200, 4'd3, 64'hCC);
    wait_sb(0, 1500, "t4_tmo_fail");
    mode = M_ACK;

    // Rx frame in progress holds off the queued message.
    wait_state(S_START_RX, 600, "t5_start_rx");
    eng_rx_busy_i = 1'b1;
    @(negedge clk_i);
    check("t5_in_rx", 64'(state_o), 64'(S_RX));
    push_exp(1'b0, 29'h300, 1);
    enq(29'h300, 4'd4, 64'hDD);
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (eng_tx_start_o) starts++;
    end
    check("t5_no_tx_start", 64'(starts), 64'd0);
    check("t5_rx_start_held", 64'(eng_rx_start_o), 64'd1);
    eng_rx_pin_i = 1'b0; eng_tx_pin_i = 1'b1; #1;
    check("t5_pin_rx0", 64'(tx_o), 64'd0);
    eng_rx_pin_i = 1'b1; eng_tx_pin_i = 1'b0; #1;
    check("t5_pin_rx1", 64'(tx_o), 64'd1);
    eng_tx_pin_i = 1'b1;
    @(negedge clk_i);
    eng_rx_busy_i = 1'b0;
    @(negedge clk_i);
    check("t5_idle", 64'({state_o, eng_rx_start_o}), 64'({S_IDLE, 1'b0}));
    @(negedge clk_i);
    check("t5_start_tx", 64'(state_o), 64'(S_START_TX));
    wait_state(S_TX, 20, "t5_tx");
    eng_tx_pin_i = 1'b0; eng_rx_pin_i = 1'b1; #1;
    check("t5_pin_tx0", 64'(tx_o), 64'd0);
    eng_tx_pin_i = 1'b1;
    wait_sb(0, 200, "t5_done");

    // Enqueue in the cycle rx ends: the start request follows 2 cycles later.
    wait_state(S_START_RX, 600, "t5b_start_rx");
    eng_rx_busy_i = 1'b1;
    @(negedge clk_i);
    check("t5b_in_rx", 64'(state_o), 64'(S_RX));
    push_exp(1'b0, 29'h301, 1);
    @(negedge clk_i);
    eng_rx_busy_i = 1'b0;
    tx_wr_i = 1'b1; tx_id_i = 29'h301; tx_dlc_i = 4'd5; tx_data_i = 64'hEE;
    @(negedge clk_i);
    tx_wr_i = 1'b0;
    check("t5b_lat1", 64'({state_o, eng_tx_start_o, tx_level_o}), 64'({S_IDLE, 1'b0, 3'd1}));
    @(negedge clk_i);
    check("t5b_lat2", 64'(eng_tx_start_o), 64'd1);
    wait_sb(0, 200, "t5b_done");

    // Reset in the middle of a frame with two messages queued.
    enq(29'h400, 4'd6, 64'h11);
    enq(29'h401, 4'd7, 64'h22);
    wait_state(S_TX, 20, "t6_tx");
    check("t6_level2", 64'(tx_level_o), 64'd2);
    rst_i = 1'b0; #1;
    check_reset_outputs("t6");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (40) @(negedge clk_i);
    check("t6_level_after", 64'(tx_level_o), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
